// File: rtl/spi_exe_pkg.sv
// Shared types and helpers for the SPI exe index/mask datapath.
// The popcount helper is sized for the widest supported mask.
package spi_exe_pkg;

   typedef enum logic {
      DEC_ONEHOT = 1'b0,
      DEC_THERMO = 1'b1
   } dec_mode_e;

   typedef enum logic [1:0] {
      DEC_IDLE,
      DEC_ACCUM,
      DEC_HOLD
   } dec_state_e;

   localparam int MAX_LEN  = 64;
   localparam int MAX_CNTW = $clog2(MAX_LEN + 1);

   function automatic logic [MAX_CNTW-1:0] count_ones(
      input logic [MAX_LEN-1:0] v
   );
      logic [MAX_CNTW-1:0] n;
      n = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         n = n + MAX_CNTW'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/bin_decoder.sv
// Binary index to one-hot or thermometer vector, with range flag.
// Out-of-range indices decode to an empty vector.
module bin_decoder
   import spi_exe_pkg::*;
#(
   parameter  int LEN  = 8,
   localparam int IDXW = $clog2(LEN)
) (
   input  logic [IDXW-1:0] idx,
   input  dec_mode_e       mode,
   output logic [LEN-1:0]  d,
   output logic            oor
);

   logic [LEN-1:0] bit_v;

   // A power-of-two width cannot encode an out-of-range index.
   if (LEN == (2 ** IDXW)) begin : g_full
      assign oor = 1'b0;
   end else begin : g_part
      assign oor = (idx >= IDXW'(LEN));
   end

   always_comb begin
      bit_v = '0;
      d     = '0;
      if (!oor) begin
         bit_v = LEN'(1) << idx;
         d     = (mode == DEC_THERMO) ? (bit_v | (bit_v - LEN'(1)))
                                      : bit_v;
      end
   end

endmodule

// File: rtl/idx_mask_decoder.sv
// Accumulates decoded indices into a mask per frame and hands the
// finished mask, popcount and sticky flags to the consumer.
module idx_mask_decoder
   import spi_exe_pkg::*;
#(
   parameter  int LEN  = 8,
   localparam int IDXW = $clog2(LEN),
   localparam int CNTW = $clog2(LEN + 1)
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [IDXW-1:0] i_idx,
   input  logic            i_mode,
   input  logic            i_last,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [LEN-1:0]  o_mask,
   output logic [CNTW-1:0] o_cnt,
   output logic            o_dup,
   output logic            o_err
);

   dec_state_e      state_q, state_d;
   logic [LEN-1:0]  mask_q, mask_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            dup_q, dup_d;
   logic            err_q, err_d;
   logic            valid_q, valid_d;
   logic [LEN-1:0]  dec;
   logic            oor;
   logic            acc;

   bin_decoder #(.LEN(LEN)) u_dec (
      .idx  (i_idx),
      .mode (dec_mode_e'(i_mode)),
      .d    (dec),
      .oor  (oor)
   );

   assign acc = i_valid && !valid_q;

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      dup_d   = dup_q;
      err_d   = err_q;
      valid_d = valid_q;
      unique case (state_q)
         DEC_IDLE, DEC_ACCUM: begin
            if (acc) begin
               mask_d = mask_q | dec;
               if (oor) begin
                  err_d = 1'b1;
               end else if ((mask_q | dec) == mask_q) begin
                  dup_d = 1'b1;
               end
               state_d = i_last ? DEC_HOLD : DEC_ACCUM;
               valid_d = i_last;
            end
         end
         DEC_HOLD: begin
            if (i_ready) begin
               state_d = DEC_IDLE;
               mask_d  = '0;
               dup_d   = 1'b0;
               err_d   = 1'b0;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = DEC_IDLE;
            mask_d  = '0;
            dup_d   = 1'b0;
            err_d   = 1'b0;
            valid_d = 1'b0;
         end
      endcase
      cnt_d = CNTW'(count_ones(MAX_LEN'(mask_d)));
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= DEC_IDLE;
         mask_q  <= '0;
         cnt_q   <= '0;
         dup_q   <= 1'b0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         dup_q   <= dup_d;
         err_q   <= err_d;
         valid_q <= valid_d;
      end
   end

   assign o_valid = valid_q;
   assign o_ready = !valid_q;
   assign o_mask  = mask_q;
   assign o_cnt   = cnt_q;
   assign o_dup   = dup_q;
   assign o_err   = err_q;

endmodule

// File: tb/tb_idx_mask_decoder.sv
// Bench for idx_mask_decoder: LEN=8 and LEN=6 instances share one
// input stream and are checked against a bit-set frame model.
module tb_idx_mask_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vld = 1'b0;
   logic       mode = 1'b0;
   logic       last = 1'b0;
   logic       rdy = 1'b0;
   logic [2:0] idx = 3'd0;

   logic       r8, v8, d8, e8;
   logic [7:0] m8;
   logic [3:0] c8;
   logic       r6, v6, d6, e6;
   logic [5:0] m6;
   logic [2:0] c6;

   int checks = 0;
   int errors = 0;
   int fr_n;
   int fr_idx[8];
   int fr_mode[8];
   int snap_mask[2], snap_cnt[2], snap_dup[2], snap_err[2];

   always #5 clk = ~clk;

   idx_mask_decoder #(.LEN(8)) u8 (
      .i_clk(clk), .i_rst(rst), .i_valid(vld), .o_ready(r8),
      .i_idx(idx), .i_mode(mode), .i_last(last), .o_valid(v8),
      .i_ready(rdy), .o_mask(m8), .o_cnt(c8), .o_dup(d8), .o_err(e8)
   );

   idx_mask_decoder #(.LEN(6)) u6 (
      .i_clk(clk), .i_rst(rst), .i_valid(vld), .o_ready(r6),
      .i_idx(idx), .i_mode(mode), .i_last(last), .o_valid(v6),
      .i_ready(rdy), .o_mask(m6), .o_cnt(c6), .o_dup(d6), .o_err(e6)
   );

   function automatic void model(input int len, output int mask,
                                 output int cnt, output int dup,
                                 output int err);
      bit set[8];
      bit fresh;
      bit hit;
      mask = 0; cnt = 0; dup = 0; err = 0;
      foreach (set[j]) set[j] = 1'b0;
      for (int k = 0; k < fr_n; k++) begin
         if (fr_idx[k] >= len) begin
            err = 1;
         end else begin
            fresh = 1'b0;
            for (int j = 0; j < len; j++) begin
               hit = fr_mode[k] != 0 ? (j <= fr_idx[k]) : (j == fr_idx[k]);
               if (hit) begin
                  if (!set[j]) fresh = 1'b1;
                  set[j] = 1'b1;
               end
            end
            if (!fresh) dup = 1;
         end
      end
      for (int j = 0; j < len; j++) begin
         if (set[j]) begin
            mask = mask | (1 << j);
            cnt++;
         end
      end
   endfunction

   task automatic run_frame(input string nm, input int rdy_wait);
      int em[2], ec[2], ed[2], ee[2];
      model(8, em[0], ec[0], ed[0], ee[0]);
      model(6, em[1], ec[1], ed[1], ee[1]);
      rdy = (rdy_wait < 0);
      for (int k = 0; k < fr_n; k++) begin
         @(negedge clk);
         vld = 1'b1;
         idx = 3'(fr_idx[k]);
         mode = fr_mode[k][0];
         last = (k == fr_n - 1);
      end
      @(negedge clk);
      vld = 1'b0;
      last = 1'b0;
      if (rdy_wait > 0) repeat (rdy_wait) @(negedge clk);
      snap_mask[0] = int'(m8); snap_cnt[0] = int'(c8);
      snap_dup[0] = int'(d8); snap_err[0] = int'(e8);
      snap_mask[1] = int'(m6); snap_cnt[1] = int'(c6);
      snap_dup[1] = int'(d6); snap_err[1] = int'(e6);
      checks++; if (v8 !== 1'b1) begin errors++; $display("FAIL %s valid8: got %b exp 1", nm, v8); end
      checks++; if (v6 !== 1'b1) begin errors++; $display("FAIL %s valid6: got %b exp 1", nm, v6); end
      checks++; if (m8 !== 8'(em[0])) begin errors++; $display("FAIL %s mask8: got %h exp %h", nm, m8, 8'(em[0])); end
      checks++; if (m6 !== 6'(em[1])) begin errors++; $display("FAIL %s mask6: got %h exp %h", nm, m6, 6'(em[1])); end
      checks++; if (c8 !== 4'(ec[0])) begin errors++; $display("FAIL %s cnt8: got %0d exp %0d", nm, c8, ec[0]); end
      checks++; if (c6 !== 3'(ec[1])) begin errors++; $display("FAIL %s cnt6: got %0d exp %0d", nm, c6, ec[1]); end
      checks++; if (d8 !== 1'(ed[0])) begin errors++; $display("FAIL %s dup8: got %b exp %0d", nm, d8, ed[0]); end
      checks++; if (d6 !== 1'(ed[1])) begin errors++; $display("FAIL %s dup6: got %b exp %0d", nm, d6, ed[1]); end
      checks++; if (e8 !== 1'(ee[0])) begin errors++; $display("FAIL %s err8: got %b exp %0d", nm, e8, ee[0]); end
      checks++; if (e6 !== 1'(ee[1])) begin errors++; $display("FAIL %s err6: got %b exp %0d", nm, e6, ee[1]); end
      rdy = 1'b1;
      @(negedge clk);
      checks++; if (v8 !== 1'b0 || r8 !== 1'b1) begin errors++; $display("FAIL %s done8: got v=%b r=%b exp v=0 r=1", nm, v8, r8); end
      checks++; if (v6 !== 1'b0 || r6 !== 1'b1) begin errors++; $display("FAIL %s done6: got v=%b r=%b exp v=0 r=1", nm, v6, r6); end
      checks++; if (m8 !== 8'h00 || c8 !== 4'd0) begin errors++; $display("FAIL %s clear8: got %h/%0d exp 00/0", nm, m8, c8); end
      rdy = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (v8 !== 1'b0 || r8 !== 1'b1 || m8 !== 8'h00) begin errors++; $display("FAIL rst_init8: got v=%b r=%b m=%h exp 0/1/00", v8, r8, m8); end
      checks++; if (c8 !== 4'd0 || d8 !== 1'b0 || e8 !== 1'b0) begin errors++; $display("FAIL rst_flags8: got c=%0d d=%b e=%b exp 0/0/0", c8, d8, e8); end
      checks++; if (v6 !== 1'b0 || r6 !== 1'b1 || m6 !== 6'h00) begin errors++; $display("FAIL rst_init6: got v=%b r=%b m=%h exp 0/1/00", v6, r6, m6); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vld = 1'b1; idx = 3'd2; mode = 1'b1; last = 1'b1;
      @(negedge clk);
      vld = 1'b0; last = 1'b0;
      checks++; if (v8 !== 1'b1 || m8 !== 8'h07) begin errors++; $display("FAIL rst_pre: got v=%b m=%h exp 1/07", v8, m8); end
      #2 rst = 1'b1;
      #1;
      checks++; if (v8 !== 1'b0 || r8 !== 1'b1 || m8 !== 8'h00 || c8 !== 4'd0) begin errors++; $display("FAIL rst_async8: got v=%b r=%b m=%h c=%0d exp 0/1/00/0", v8, r8, m8, c8); end
      checks++; if (v6 !== 1'b0 || r6 !== 1'b1 || m6 !== 6'h00) begin errors++; $display("FAIL rst_async6: got v=%b r=%b m=%h exp 0/1/00", v6, r6, m6); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_onehot();
      fr_n = 3;
      fr_idx[0] = 1; fr_idx[1] = 4; fr_idx[2] = 6;
      fr_mode[0] = 0; fr_mode[1] = 0; fr_mode[2] = 0;
      run_frame("onehot", -1);
      checks++; if (snap_mask[0] != 'h52 || snap_cnt[0] != 3 || snap_dup[0] != 0 || snap_err[0] != 0) begin errors++; $display("FAIL onehot_spec: got %h/%0d/%0d/%0d exp 52/3/0/0", snap_mask[0], snap_cnt[0], snap_dup[0], snap_err[0]); end
   endtask

   task automatic test_thermo();
      fr_n = 1; fr_idx[0] = 5; fr_mode[0] = 1;
      run_frame("thermo", 2);
      checks++; if (snap_mask[0] != 'h3F || snap_cnt[0] != 6) begin errors++; $display("FAIL thermo_spec: got %h/%0d exp 3f/6", snap_mask[0], snap_cnt[0]); end
   endtask

   task automatic test_dup();
      fr_n = 2; fr_idx[0] = 3; fr_idx[1] = 3;
      fr_mode[0] = 0; fr_mode[1] = 0;
      run_frame("dup", 0);
      checks++; if (snap_mask[0] != 'h08 || snap_cnt[0] != 1 || snap_dup[0] != 1) begin errors++; $display("FAIL dup_spec: got %h/%0d/%0d exp 08/1/1", snap_mask[0], snap_cnt[0], snap_dup[0]); end
   endtask

   task automatic test_oor();
      fr_n = 2; fr_idx[0] = 7; fr_idx[1] = 2;
      fr_mode[0] = 0; fr_mode[1] = 0;
      run_frame("oor", 1);
      checks++; if (snap_mask[1] != 'h04 || snap_err[1] != 1 || snap_err[0] != 0) begin errors++; $display("FAIL oor_spec: got m6=%h e6=%0d e8=%0d exp 04/1/0", snap_mask[1], snap_err[1], snap_err[0]); end
   endtask

   task automatic test_reset_accum();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         vld = 1'b1; idx = 3'(k); mode = 1'b0; last = 1'b0;
      end
      @(negedge clk);
      vld = 1'b0;
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      fr_n = 1; fr_idx[0] = 5; fr_mode[0] = 0;
      run_frame("rst_accum", 0);
      checks++; if (snap_mask[0] != 'h20 || snap_mask[1] != 'h20) begin errors++; $display("FAIL rst_accum_spec: got %h/%h exp 20/20", snap_mask[0], snap_mask[1]); end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      vld = 1'b1; idx = 3'd0; mode = 1'b0; last = 1'b1; rdy = 1'b0;
      @(negedge clk);
      idx = 3'd7; last = 1'b0;
      repeat (5) begin
         @(negedge clk);
         checks++; if (r8 !== 1'b0 || v8 !== 1'b1 || m8 !== 8'h01 || r6 !== 1'b0 || m6 !== 6'h01) begin errors++; $display("FAIL bp_hold: got r8=%b v8=%b m8=%h r6=%b m6=%h exp 0/1/01/0/01", r8, v8, m8, r6, m6); end
      end
      rdy = 1'b1;
      @(negedge clk);
      checks++; if (v8 !== 1'b0 || r8 !== 1'b1 || m8 !== 8'h00) begin errors++; $display("FAIL bp_bubble: got v=%b r=%b m=%h exp 0/1/00", v8, r8, m8); end
      @(negedge clk);
      rdy = 1'b0;
      checks++; if (m8 !== 8'h80 || m6 !== 6'h00 || v8 !== 1'b0) begin errors++; $display("FAIL bp_first: got m8=%h m6=%h v=%b exp 80/00/0", m8, m6, v8); end
      idx = 3'd2; last = 1'b1;
      @(negedge clk);
      vld = 1'b0; last = 1'b0;
      checks++; if (v8 !== 1'b1 || m8 !== 8'h84 || c8 !== 4'd2 || e8 !== 1'b0) begin errors++; $display("FAIL bp_res8: got v=%b m=%h c=%0d e=%b exp 1/84/2/0", v8, m8, c8, e8); end
      checks++; if (m6 !== 6'h04 || e6 !== 1'b1 || c6 !== 3'd1) begin errors++; $display("FAIL bp_res6: got m=%h e=%b c=%0d exp 04/1/1", m6, e6, c6); end
      rdy = 1'b1;
      @(negedge clk);
      rdy = 1'b0;
      checks++; if (v8 !== 1'b0 || v6 !== 1'b0) begin errors++; $display("FAIL bp_done: got %b/%b exp 0/0", v8, v6); end
   endtask

   task automatic test_random();
      for (int f = 0; f < 40; f++) begin
         fr_n = int'($urandom_range(1, 5));
         for (int k = 0; k < fr_n; k++) begin
            fr_idx[k] = int'($urandom_range(0, 7));
            fr_mode[k] = int'($urandom_range(0, 1));
         end
         run_frame("random", int'($urandom_range(0, 4)) - 1);
      end
   endtask

   initial begin
      test_reset();
      test_onehot();
      test_thermo();
      test_dup();
      test_oor();
      test_reset_accum();
      test_backpressure();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/idx_mask_decoder.md
Name: idx_mask_decoder

Overview:
- Inverse of the SPI exe unit's priority encoder: converts a stream of binary indices into a LEN-bit mask.
- Each index is decoded to one-hot, or to thermometer form, and OR-accumulated into a mask register over a frame terminated by i_last.
- The finished mask is presented with a valid/ready handshake, together with its popcount and a duplicate-index flag.
- Sits between the SPI command sequencer (index producer) and the chip-select/lane-enable register consumer.

Parameters:
- LEN, 8, mask width in bits; must be >= 2.
- IDXW, $clog2(LEN), index width; derived localparam, not overridable.
- CNTW, $clog2(LEN+1), popcount width; derived localparam.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  input index beat valid.
- o_ready  out  1  block can accept an index beat.
- i_idx  in  IDXW  binary index.
- i_mode  in  1  0 = one-hot (bit idx only); 1 = thermometer (bits idx..0).
- i_last  in  1  beat closes the frame.
- o_valid  out  1  frame result valid.
- i_ready  in  1  consumer accepts result.
- o_mask  out  LEN  accumulated mask.
- o_cnt  out  CNTW  number of set bits in o_mask.
- o_dup  out  1  at least one beat in the frame added no new bit.
- o_err  out  1  at least one beat in the frame had i_idx >= LEN.

Behaviour:
- Reset (async, immediate):
  - State IDLE; mask, cnt, dup and err all 0.
  - o_valid = 0; o_ready = 1.
- Input handshake: a beat is accepted on a rising edge with i_valid && o_ready. i_idx, i_mode and i_last are sampled only on that edge.
- Output handshake: the result is consumed on a rising edge with o_valid && i_ready. o_mask, o_cnt, o_dup and o_err stay stable while o_valid=1.
- States:
  - IDLE: o_ready=1, o_valid=0, mask=0.
    - Accepted beat with i_last=0 -> ACCUM.
    - Accepted beat with i_last=1 -> HOLD.
  - ACCUM: o_ready=1, o_valid=0.
    - Accepted beat with i_last=1 -> HOLD; otherwise stay.
  - HOLD: o_ready=0, o_valid=1.
    - Output handshake -> IDLE; mask, cnt, dup and err clear on the same edge.
- Decode per accepted beat: d = mode ? ((1<<(idx+1))-1) : (1<<idx), truncated to LEN; then mask <= mask | d.
- Out-of-range index (only possible when LEN is not a power of two):
  - d = 0 and err <= 1.
  - The beat still counts toward framing and i_last is honoured.
- Duplicate flag: if (mask | d) == mask for an in-range beat, dup <= 1 (sticky until the result is consumed).
- o_cnt is registered and updated on the same edge as mask. Latency: the result is visible 1 cycle after the i_last beat is accepted.
- Throughput: 1 beat/cycle within a frame. There is at least one bubble cycle between frames: o_ready=0 in HOLD, and the state is back in IDLE on the edge after the handshake.
- i_valid while in HOLD is ignored; the producer holds the beat.
- i_ready while o_valid=0 is ignored.
- Reset mid-frame or in HOLD discards the partial or pending result; there is no output pulse.
- Combinational paths: none from inputs to o_ready or o_valid.

Decomposition:
- Package spi_exe_pkg:
  - typedef dec_mode_e {DEC_ONEHOT=1'b0, DEC_THERMO=1'b1}.
  - typedef dec_state_e {DEC_IDLE, DEC_ACCUM, DEC_HOLD}.
- Sub-module bin_decoder (combinational, parameter LEN): inputs idx and mode; outputs d and oor (out-of-range).
- Popcount is a function in the package, count_ones(LEN-bit) -> CNTW.
- FSM, accumulation and sticky flags live in idx_mask_decoder.

Test Plan:
- Reset with i_rst pulsed mid-clock -> o_valid=0, o_ready=1, o_mask=0 immediately, without waiting for a clock edge.
- LEN=8, one-hot beats idx 1, 4, 6 (last) with i_ready=1 -> o_valid high for 1 cycle, o_mask=8'b0101_0010, o_cnt=3, o_dup=0, o_err=0.
- Thermometer single beat idx=5, last -> o_mask=8'h3F, o_cnt=6.
- Duplicates: one-hot idx 3 then idx 3 (last) -> o_mask=8'h08, o_cnt=1, o_dup=1.
- Backpressure: hold i_ready=0 for 5 cycles while i_valid stays 1 with the next frame's beat -> o_ready=0, o_mask stable, no beat accepted. After i_ready=1, the new frame starts from mask 0.
- LEN=6, idx=7 beat then idx=2 (last), one-hot -> o_mask=6'b000100, o_err=1. Separately, reset asserted in ACCUM after 2 beats -> the next frame's result contains only its own bits.
